router_pkt_receiver: RTL and testbench
======================================

// Module: router_pkt_receiver
// PURPOSE
//  Downstream drain for one router output port; one instance per port, on data_out_N/vld_out_N/read_enb_N.
//  Pops a packet byte-by-byte: header {len[7:2],addr[1:0]}, len payload bytes, then parity (XOR of header and payload).
//  Forwards payload bytes with framing, checks parity, and reports length, address and status per packet.
//  Drains promptly so the port's 30-cycle soft-reset timeout does not fire while the sink is ready.
// PARAMETERS
//  DATA_W     8   byte width (fixed 8 for the header format)
//  STALL_MAX  32  idle cycles in BODY with vld_out low before the packet is aborted
//  CNT_W      16  width of the statistics counters
// PORTS
//  clock       in   1       single clock, rising edge
//  reset       in   1       asynchronous, active-high
//  vld_out     in   1       port FIFO non-empty
//  data_out    in   DATA_W  port FIFO read data; valid the cycle after read_enb
//  sink_ready  in   1       consumer can take a payload byte next cycle
//  read_enb    out  1       FIFO pop request (combinational)
//  byte_out    out  DATA_W  payload byte (registered)
//  byte_valid  out  1       byte_out valid, one-cycle pulse per byte
//  sop / eop   out  1       first / last payload byte, qualified by byte_valid
//  pkt_len     out  6       header length of the last completed packet
//  pkt_addr    out  2       header address of the last completed packet
//  pkt_done    out  1       one-cycle pulse at end of packet, normal or aborted
//  parity_err  out  1       valid with pkt_done: computed XOR != parity byte
//  pkt_abort   out  1       valid with pkt_done: packet aborted by stall
//  pkt_count   out  CNT_W   completed packets (PKT_STATS_EN)
//  err_count   out  CNT_W   parity errors plus aborts (PKT_STATS_EN)
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-high.
//  Reset: every output and register is 0; state is IDLE.
//  Reset mid-packet discards the partial packet with no pkt_done. The bench must also drain or soft-reset the FIFO.
//  Read latency: a byte popped with read_enb=1 at edge N is captured from data_out at edge N+1.
//  States:
//   IDLE     read_enb = vld_out. If 1, go to HDR.
//   HDR      capture the header; xor <= header; left <= len+1; issued <= 0; go to BODY. read_enb = 0 here.
//   BODY     read_enb = vld_out & sink_ready & (issued < left). Each byte captured is counted in rcvd.
//            While rcvd < len: the byte is payload. byte_out <= byte; byte_valid = 1; xor ^= byte;
//            sop when rcvd == 0; eop when rcvd == len-1.
//            When rcvd == len: the byte is parity. parity_err <= (xor != byte). Go to DONE.
//   DONE     pkt_done = 1 for one cycle. pkt_len and pkt_addr are updated. Go to IDLE.
//  Length 0 is legal: only the parity byte is read; no byte_valid, sop or eop.
//  sop and eop are both set on the single byte when len = 1.
//  Back-pressure: sink_ready low blocks new pops only. A pop already in flight still lands as byte_valid,
//  so the sink must absorb one byte after it drops ready.
//  Stall: stall_cnt counts BODY cycles with vld_out = 0 and no capture. Any capture clears it.
//  At STALL_MAX the packet is aborted: DONE with pkt_abort = 1 and parity_err = 0.
//  An aborted packet emits no eop. Stall is not counted while sink_ready = 0 and vld_out = 1.
//  pkt_done, parity_err and pkt_abort are registered. parity_err and pkt_abort are 0 outside the DONE cycle.
//  read_enb is never asserted while vld_out = 0, or in HDR or DONE.
//  The receiver never over-reads past the parity byte: it issues exactly len+2 pops per packet.
//  Counters wrap modulo 2^CNT_W.
// CONFIGURATION
//  PKT_STATS_EN defined: pkt_count increments on every pkt_done.
//    err_count increments on pkt_done & (parity_err | pkt_abort).
//  PKT_STATS_EN undefined: both ports remain and are tied to 0; no counter flops are built.
// TESTING
//  1 Good packet, len 3, addr 0: FIFO holds 0C,11,22,33,0C; sink_ready=1.
//    -> 11,22,33 on byte_out, sop on 11, eop on 33; pkt_done with pkt_len=3, pkt_addr=0, parity_err=0;
//    -> exactly 5 read_enb pulses.
//  2 Same packet with parity 0D -> pkt_done with parity_err=1; err_count=1 under PKT_STATS_EN.
//  3 Length 0: 02,02 -> no byte_valid; pkt_done with pkt_len=0, pkt_addr=2, parity_err=0; 2 pops.
//  4 Length 20 packet, sink_ready low for 10 cycles mid-body
//    -> read_enb low during the gap; at most one byte_valid after ready drops; all 20 bytes in order.
//  5 Length 8 packet, vld_out low after 4 payload bytes for 32 cycles
//    -> pkt_done with pkt_abort=1; back to IDLE; a following good packet is received cleanly.
//  6 Reset asserted mid-body -> all outputs 0 immediately (asynchronous).
//    After release and a fresh packet: normal reception and pkt_count restarts from 0.

Source files
------------

// File: rtl/router_pkt_receiver.sv
// router_pkt_receiver: drains one router output port FIFO one byte at a time.
// Each packet is a header {len[7:2],addr[1:0]}, then len payload bytes, then a
// parity byte equal to the XOR of the header and the payload. The receiver
// forwards payload bytes with sop/eop framing, checks the parity, and reports
// the length, address and status of each completed packet.
// Optional feature: define PKT_STATS_EN to build the pkt_count/err_count
// counters. When it is undefined, both ports stay and are tied to 0.
// Ports:
//   clock, reset             single clock; asynchronous active-high reset
//   vld_out, data_out        port FIFO non-empty / read data (one cycle after pop)
//   sink_ready               consumer can take a payload byte next cycle
//   read_enb                 FIFO pop request (combinational)
//   byte_out, byte_valid     forwarded payload byte and its one-cycle strobe
//   sop, eop                 first / last payload byte, qualified by byte_valid
//   pkt_len, pkt_addr        header fields of the last completed packet
//   pkt_done                 end-of-packet pulse (normal or aborted)
//   parity_err, pkt_abort    status, valid only with pkt_done
//   pkt_count, err_count     statistics counters (PKT_STATS_EN)
module router_pkt_receiver #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STALL_MAX = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              sink_ready,
  output logic              read_enb,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              sop,
  output logic              eop,
  output logic [5:0]        pkt_len,
  output logic [1:0]        pkt_addr,
  output logic              pkt_done,
  output logic              parity_err,
  output logic              pkt_abort,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned LEN_W   = 6;
  localparam int unsigned CNT7_W  = LEN_W + 1;
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {IDLE, HDR, BODY, DONE} state_t;

  state_t              state, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          addr_q, addr_d;
  logic [CNT7_W-1:0]   left_q, left_d;
  logic [CNT7_W-1:0]   issued_q, issued_d;
  logic [CNT7_W-1:0]   rcvd_q, rcvd_d;
  logic [DATA_W-1:0]   xor_q, xor_d;
  logic                pend_q, pend_d;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic [DATA_W-1:0]   byte_out_d;
  logic                byte_valid_d, sop_d, eop_d;
  logic [5:0]          pkt_len_d;
  logic [1:0]          pkt_addr_d;
  logic                pkt_done_d, parity_err_d, pkt_abort_d;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      addr_q     <= '0;
      left_q     <= '0;
      issued_q   <= '0;
      rcvd_q     <= '0;
      xor_q      <= '0;
      pend_q     <= 1'b0;
      stall_q    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      pkt_len    <= '0;
      pkt_addr   <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      state      <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      issued_q   <= issued_d;
      rcvd_q     <= rcvd_d;
      xor_q      <= xor_d;
      pend_q     <= pend_d;
      stall_q    <= stall_d;
      byte_out   <= byte_out_d;
      byte_valid <= byte_valid_d;
      sop        <= sop_d;
      eop        <= eop_d;
      pkt_len    <= pkt_len_d;
      pkt_addr   <= pkt_addr_d;
      pkt_done   <= pkt_done_d;
      parity_err <= parity_err_d;
      pkt_abort  <= pkt_abort_d;
    end
  end

  // Next-state, pop request and next register values
  always_comb begin
    state_d      = state;
    len_d        = len_q;
    addr_d       = addr_q;
    left_d       = left_q;
    issued_d     = issued_q;
    rcvd_d       = rcvd_q;
    xor_d        = xor_q;
    pend_d       = 1'b0;
    stall_d      = stall_q;
    byte_out_d   = byte_out;
    byte_valid_d = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    pkt_len_d    = pkt_len;
    pkt_addr_d   = pkt_addr;
    pkt_done_d   = 1'b0;
    parity_err_d = 1'b0;
    pkt_abort_d  = 1'b0;
    read_enb     = 1'b0;

    unique case (state)
      IDLE: begin
        read_enb = vld_out;
        if (vld_out) state_d = HDR;
      end
      HDR: begin
        len_d    = data_out[7:2];
        addr_d   = data_out[1:0];
        xor_d    = data_out;
        left_d   = CNT7_W'(data_out[7:2]) + CNT7_W'(1);
        issued_d = '0;
        rcvd_d   = '0;
        stall_d  = '0;
        state_d  = BODY;
      end
      BODY: begin
        // left = len payload pops + 1 parity pop; never pop beyond it
        read_enb = vld_out & sink_ready & (issued_q < left_q);
        pend_d   = read_enb;
        if (read_enb) issued_d = issued_q + CNT7_W'(1);

        if (pend_q) begin
          stall_d = '0;
          rcvd_d  = rcvd_q + CNT7_W'(1);
          if (rcvd_q < CNT7_W'(len_q)) begin
            byte_out_d   = data_out;
            byte_valid_d = 1'b1;
            xor_d        = xor_q ^ data_out;
            sop_d        = (rcvd_q == '0);
            eop_d        = (rcvd_q == CNT7_W'(len_q) - CNT7_W'(1));
          end else begin
            parity_err_d = (xor_q != data_out);
            pkt_done_d   = 1'b1;
            pkt_len_d    = len_q;
            pkt_addr_d   = addr_q;
            state_d      = DONE;
          end
        end else if (!vld_out) begin
          // No pop can be in flight here since vld_out is low this cycle
          if (stall_q == STALL_W'(STALL_MAX - 1)) begin
            stall_d     = '0;
            pkt_done_d  = 1'b1;
            pkt_abort_d = 1'b1;
            pkt_len_d   = len_q;
            pkt_addr_d  = addr_q;
            state_d     = DONE;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PKT_STATS_EN
  // Statistics counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
      err_count <= '0;
    end else if (pkt_done) begin
      pkt_count <= pkt_count + CNT_W'(1);
      if (parity_err | pkt_abort) err_count <= err_count + CNT_W'(1);
    end
  end
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_router_pkt_receiver.sv
// Self-checking bench for router_pkt_receiver: a queue-based port FIFO model
// feeds the receiver; expected payload bytes and packet reports go into
// scoreboard queues and are compared as the DUT produces them.
module tb_router_pkt_receiver;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
`ifdef PKT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    logic       s;
    logic       e;
  } exp_byte_t;

  typedef struct {
    logic [5:0] len;
    logic [1:0] addr;
    logic       perr;
    logic       abort;
  } exp_pkt_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              vld_out;
  logic [DATA_W-1:0] data_out;
  logic              sink_ready;
  logic              read_enb;
  logic [DATA_W-1:0] byte_out;
  logic              byte_valid, sop, eop;
  logic [5:0]        pkt_len;
  logic [1:0]        pkt_addr;
  logic              pkt_done, parity_err, pkt_abort;
  logic [CNT_W-1:0]  pkt_count, err_count;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] fifo[$];
  exp_byte_t  exp_q[$];
  exp_pkt_t   exp_pk[$];
  int         pushed = 0;
  int         popped = 0;
  logic       hold = 1'b1;
  int         bv_cnt = 0;
  int         done_cnt = 0;
  int         exp_pkts = 0;
  int         exp_errs = 0;

  router_pkt_receiver #(.DATA_W(DATA_W), .STALL_MAX(32), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
    .sink_ready(sink_ready), .read_enb(read_enb), .byte_out(byte_out),
    .byte_valid(byte_valid), .sop(sop), .eop(eop), .pkt_len(pkt_len),
    .pkt_addr(pkt_addr), .pkt_done(pkt_done), .parity_err(parity_err),
    .pkt_abort(pkt_abort), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  assign vld_out = (pushed != popped) && !hold;

  // Port FIFO model: read data appears the cycle after the pop
  always @(posedge clock) begin
    if (read_enb) begin
      popped <= popped + 1;
      if (fifo.size() > 0) data_out <= fifo.pop_front();
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay(input logic [7:0] base, input int i);
    return base + 8'(8'h11 * (i + 1));
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    pushed++;
  endtask

  // Queue a full packet; bad_par flips the parity's low bit
  task automatic push_pkt(input int len, input logic [1:0] addr, input logic [7:0] base,
                          input bit bad_par);
    logic [7:0] hdr;
    logic [7:0] par;
    exp_byte_t  eb;
    exp_pkt_t   ep;
    hdr = {6'(len), addr};
    par = hdr;
    push_byte(hdr);
    for (int i = 0; i < len; i++) begin
      push_byte(pay(base, i));
      par = par ^ pay(base, i);
      eb.b = pay(base, i);
      eb.s = (i == 0);
      eb.e = (i == len - 1);
      exp_q.push_back(eb);
    end
    push_byte(bad_par ? (par ^ 8'h01) : par);
    ep.len = 6'(len); ep.addr = addr; ep.perr = bad_par; ep.abort = 1'b0;
    exp_pk.push_back(ep);
    exp_pkts++;
    if (bad_par) exp_errs++;
  endtask

  task automatic wait_done(input string tag);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(done_cnt != start), 32'd1);
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (bv_cnt < target && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("bytes_timeout", 32'(bv_cnt >= target), 32'd1);
  endtask

  task automatic check_stats(input string tag);
    @(negedge clock);
    check({tag, "_pkt_count"}, 32'(pkt_count), STATS ? 32'(exp_pkts) : 32'd0);
    check({tag, "_err_count"}, 32'(err_count), STATS ? 32'(exp_errs) : 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset) begin
      if (read_enb) check("rd_without_vld", 32'(vld_out), 32'd1);
      if (byte_valid) begin
        bv_cnt++;
        if (exp_q.size() == 0) check("unexpected_byte", 32'(byte_out), 32'hFFFF_FFFF);
        else begin
          exp_byte_t e;
          e = exp_q.pop_front();
          check("byte_out", 32'(byte_out), 32'(e.b));
          check("sop", 32'(sop), 32'(e.s));
          check("eop", 32'(eop), 32'(e.e));
        end
      end
      if (pkt_done) begin
        done_cnt++;
        if (exp_pk.size() == 0) check("unexpected_done", 32'(pkt_done), 32'd0);
        else begin
          exp_pkt_t p;
          p = exp_pk.pop_front();
          check("pkt_len", 32'(pkt_len), 32'(p.len));
          check("pkt_addr", 32'(pkt_addr), 32'(p.addr));
          check("parity_err", 32'(parity_err), 32'(p.perr));
          check("pkt_abort", 32'(pkt_abort), 32'(p.abort));
        end
      end else if (parity_err || pkt_abort) begin
        check("status_outside_done", 32'({parity_err, pkt_abort}), 32'd0);
      end
    end
  end

  initial begin
    int p0;
    int gap_bv;
    exp_byte_t eb;
    exp_pkt_t  ep;

    reset = 1'b1;
    sink_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_outputs", 32'({byte_valid, sop, eop, pkt_done, parity_err, pkt_abort, read_enb}), 32'd0);
    check("rst_fields", 32'({byte_out, pkt_len, pkt_addr}), 32'd0);
    check("rst_counts", 32'({pkt_count, err_count}), 32'd0);
    reset = 1'b0;
    hold = 1'b0;
    @(negedge clock);

    // 1: good packet len 3 addr 0 -> 0C 11 22 33 0C
    p0 = popped;
    push_pkt(3, 2'd0, 8'h00, 1'b0);
    wait_done("t1_done");
    check_stats("t1");
    check("t1_pops", 32'(popped - p0), 32'd5);

    // 2: same packet with parity 0D
    push_pkt(3, 2'd0, 8'h00, 1'b1);
    wait_done("t2_done");
    check_stats("t2");

    // 3: length 0, addr 2 -> 02 02
    p0 = popped;
    push_pkt(0, 2'd2, 8'h00, 1'b0);
    wait_done("t3_done");
    check_stats("t3");
    check("t3_pops", 32'(popped - p0), 32'd2);

    // 4: length 20 with a 10-cycle sink_ready gap mid-body
    p0 = popped;
    push_pkt(20, 2'd1, 8'h05, 1'b0);
    wait_bytes(bv_cnt + 5);
    sink_ready = 1'b0;
    gap_bv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (read_enb) check("t4_rd_in_gap", 32'(read_enb), 32'd0);
      if (byte_valid) gap_bv++;
    end
    check("t4_gap_bytes_le1", 32'(gap_bv <= 1), 32'd1);
    sink_ready = 1'b1;
    wait_done("t4_done");
    check_stats("t4");
    check("t4_pops", 32'(popped - p0), 32'd22);
    check("t4_all_bytes", 32'(exp_q.size()), 32'd0);

    // 5: length 8, only 4 payload bytes ever arrive -> stall abort
    p0 = popped;
    push_byte({6'd8, 2'd3});
    for (int i = 0; i < 4; i++) begin
      push_byte(pay(8'h40, i));
      eb.b = pay(8'h40, i); eb.s = (i == 0); eb.e = 1'b0;
      exp_q.push_back(eb);
    end
    ep.len = 6'd8; ep.addr = 2'd3; ep.perr = 1'b0; ep.abort = 1'b1;
    exp_pk.push_back(ep);
    exp_pkts++;
    exp_errs++;
    wait_done("t5_abort_done");
    check_stats("t5");
    check("t5_pops", 32'(popped - p0), 32'd5);
    push_pkt(2, 2'd1, 8'h77, 1'b0);
    wait_done("t5_next_done");
    check_stats("t5_next");

    // 6: reset mid-body, then a fresh packet
    push_pkt(10, 2'd2, 8'h30, 1'b0);
    wait_bytes(bv_cnt + 3);
    hold = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("t6_async_outputs", 32'({byte_valid, sop, eop, pkt_done, parity_err, pkt_abort, read_enb}), 32'd0);
    check("t6_async_fields", 32'({byte_out, pkt_len, pkt_addr}), 32'd0);
    check("t6_async_counts", 32'({pkt_count, err_count}), 32'd0);
    fifo.delete();
    exp_q.delete();
    exp_pk.delete();
    exp_pkts = 0;
    exp_errs = 0;
    @(negedge clock);
    pushed = popped;
    reset = 1'b0;
    hold = 1'b0;
    @(negedge clock);
    p0 = popped;
    push_pkt(4, 2'd3, 8'h21, 1'b0);
    wait_done("t6_done");
    check_stats("t6");
    check("t6_pops", 32'(popped - p0), 32'd6);
    check("t6_all_bytes", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
